arbitro_memoria: RTL and testbench

ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

---
 rtl/arbitro_memoria_if.sv | 47 ++++
 rtl/arbitro_memoria.sv | 123 ++++++++++++
 tb/tb_arbitro_memoria.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_memoria_if.sv
// Bus bundle for the two-port memory arbiter:
// port A (core), port B (loader) and the shared memory side.
interface arbitro_memoria_if;
   logic        a_req;
   logic        a_esc;
   logic [31:0] a_dir;
   logic [31:0] a_dato_esc;
   logic [3:0]  a_mascara;
   logic        a_listo;
   logic        a_error;
   logic [31:0] a_dato_lec;

   logic        b_req;
   logic        b_esc;
   logic [31:0] b_dir;
   logic [31:0] b_dato_esc;
   logic [3:0]  b_mascara;
   logic        b_listo;
   logic        b_error;
   logic [31:0] b_dato_lec;

   logic        m_sel;
   logic        m_esc;
   logic [31:0] m_dir;
   logic [31:0] m_dato_esc;
   logic [3:0]  m_mascara;
   logic [31:0] m_dato_lec;
   logic        m_listo;

   modport master (
      input  a_req, a_esc, a_dir, a_dato_esc, a_mascara,
      output a_listo, a_error, a_dato_lec,
      input  b_req, b_esc, b_dir, b_dato_esc, b_mascara,
      output b_listo, b_error, b_dato_lec,
      output m_sel, m_esc, m_dir, m_dato_esc, m_mascara,
      input  m_dato_lec, m_listo
   );

   modport slave (
      output a_req, a_esc, a_dir, a_dato_esc, a_mascara,
      input  a_listo, a_error, a_dato_lec,
      output b_req, b_esc, b_dir, b_dato_esc, b_mascara,
      input  b_listo, b_error, b_dato_lec,
      input  m_sel, m_esc, m_dir, m_dato_esc, m_mascara,
      output m_dato_lec, m_listo
   );
endinterface

// File: rtl/arbitro_memoria.sv
// Two-port memory arbiter: alternating priority on conflict,
// one access at a time, with a wait-cycle timeout.
module arbitro_memoria #(
   parameter int unsigned ESPERA_MAX = 15
) (
   input logic               clk,
   input logic               reset,
   arbitro_memoria_if.master bus
);

   typedef enum logic [1:0] {
      LIBRE,
      ACCESO_A,
      ACCESO_B,
      RESPUESTA
   } estado_t;

   localparam logic [7:0] CUENTA_FIN = 8'(ESPERA_MAX - 1);

   estado_t    estado;
   estado_t    estado_sig;
   logic       ultimo;
   logic [7:0] cuenta;
   logic       gana_a;
   logic       gana_b;
   logic       acceso;
   logic       fin_ok;
   logic       fin_to;

   // ultimo = 1 means B holds the most recent grant
   assign gana_a = (estado == LIBRE) && bus.a_req
                   && (!bus.b_req || ultimo);
   assign gana_b = (estado == LIBRE) && bus.b_req
                   && (!bus.a_req || !ultimo);
   assign acceso = (estado == ACCESO_A)
                   || (estado == ACCESO_B);
   assign fin_ok = acceso && bus.m_listo;
   assign fin_to = acceso && !bus.m_listo
                   && (cuenta == CUENTA_FIN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado <= LIBRE;
      end else begin
         estado <= estado_sig;
      end
   end

   always_comb begin
      estado_sig = estado;
      unique case (estado)
         LIBRE: begin
            unique case (1'b1)
               gana_a:  estado_sig = ACCESO_A;
               gana_b:  estado_sig = ACCESO_B;
               default: estado_sig = LIBRE;
            endcase
         end
         ACCESO_A,
         ACCESO_B: begin
            if (fin_ok || fin_to) begin
               estado_sig = RESPUESTA;
            end
         end
         RESPUESTA: estado_sig = LIBRE;
         default:   estado_sig = LIBRE;
      endcase
   end

   always_comb begin
      bus.m_sel   = acceso;
      bus.a_listo = (estado == RESPUESTA) && !ultimo;
      bus.b_listo = (estado == RESPUESTA) && ultimo;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ultimo         <= 1'b1;
         cuenta         <= 8'd0;
         bus.m_esc      <= 1'b0;
         bus.m_dir      <= 32'd0;
         bus.m_dato_esc <= 32'd0;
         bus.m_mascara  <= 4'd0;
      end else if (gana_a) begin
         ultimo         <= 1'b0;
         cuenta         <= 8'd0;
         bus.m_esc      <= bus.a_esc;
         bus.m_dir      <= bus.a_dir;
         bus.m_dato_esc <= bus.a_dato_esc;
         bus.m_mascara  <= bus.a_mascara;
      end else if (gana_b) begin
         ultimo         <= 1'b1;
         cuenta         <= 8'd0;
         bus.m_esc      <= bus.b_esc;
         bus.m_dir      <= bus.b_dir;
         bus.m_dato_esc <= bus.b_dato_esc;
         bus.m_mascara  <= bus.b_mascara;
      end else if (acceso && !bus.m_listo) begin
         cuenta <= cuenta + 8'd1;
      end
   end

   // completion wins over timeout in the same cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.a_error    <= 1'b0;
         bus.a_dato_lec <= 32'd0;
         bus.b_error    <= 1'b0;
         bus.b_dato_lec <= 32'd0;
      end else if (fin_ok || fin_to) begin
         if (estado == ACCESO_A) begin
            bus.a_error    <= fin_to;
            bus.a_dato_lec <= (fin_ok && !bus.m_esc)
                              ? bus.m_dato_lec : 32'd0;
         end else begin
            bus.b_error    <= fin_to;
            bus.b_dato_lec <= (fin_ok && !bus.m_esc)
                              ? bus.m_dato_lec : 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria: vector table
// plus hand sequences for conflict, idle and reset cases.
module tb_arbitro_memoria;

   localparam int EMAX = 15;

   typedef struct {
      logic        a_req;
      logic        b_req;
      logic        a_esc;
      logic        b_esc;
      logic [31:0] a_dir;
      logic [31:0] b_dir;
      logic [31:0] a_wd;
      logic [31:0] b_wd;
      logic [3:0]  a_msk;
      logic [3:0]  b_msk;
      int          espera;
      logic [31:0] m_rd;
      logic        srv_b;
      logic        exp_err;
      logic [31:0] exp_dat;
   } vec_t;

   logic clk = 1'b0;
   logic reset;

   arbitro_memoria_if bus ();

   arbitro_memoria #(.ESPERA_MAX(EMAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int pass  = 0;

   logic [31:0] ea_dat = 32'd0;
   logic [31:0] eb_dat = 32'd0;
   logic        ea_err = 1'b0;
   logic        eb_err = 1'b0;

   vec_t tabla [9];

   task automatic chk(input string nom,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %h expected %h",
                    nom, act, exp);
   endtask

   task automatic chk_puertos(input string nom);
      chk({nom, " a_error"}, 32'(bus.a_error), 32'(ea_err));
      chk({nom, " a_dato_lec"}, bus.a_dato_lec, ea_dat);
      chk({nom, " b_error"}, 32'(bus.b_error), 32'(eb_err));
      chk({nom, " b_dato_lec"}, bus.b_dato_lec, eb_dat);
   endtask

   // Entered and left #1 after a rising edge with the DUT in LIBRE.
   task automatic run_vec(input int n, input vec_t v);
      logic [31:0] xd;
      logic [31:0] xw;
      logic [3:0]  xm;
      logic        xe;
      string       p;
      p = $sformatf("v%0d", n);
      bus.a_req      = v.a_req;
      bus.b_req      = v.b_req;
      bus.a_esc      = v.a_esc;
      bus.b_esc      = v.b_esc;
      bus.a_dir      = v.a_dir;
      bus.b_dir      = v.b_dir;
      bus.a_dato_esc = v.a_wd;
      bus.b_dato_esc = v.b_wd;
      bus.a_mascara  = v.a_msk;
      bus.b_mascara  = v.b_msk;
      bus.m_dato_lec = v.m_rd;
      bus.m_listo    = 1'b0;
      xd = v.srv_b ? v.b_dir : v.a_dir;
      xw = v.srv_b ? v.b_wd : v.a_wd;
      xm = v.srv_b ? v.b_msk : v.a_msk;
      xe = v.srv_b ? v.b_esc : v.a_esc;
      @(posedge clk); #1;
      for (int c = 0; c < EMAX; c++) begin
         chk({p, " m_sel"}, 32'(bus.m_sel), 32'd1);
         chk({p, " m_dir"}, bus.m_dir, xd);
         chk({p, " m_esc"}, 32'(bus.m_esc), 32'(xe));
         chk({p, " m_dato_esc"}, bus.m_dato_esc, xw);
         chk({p, " m_mascara"}, 32'(bus.m_mascara), 32'(xm));
         bus.m_listo = (c == v.espera);
         @(posedge clk); #1;
         if (c == v.espera) break;
      end
      bus.m_listo = 1'b0;
      if (v.srv_b) begin
         eb_err = v.exp_err;
         eb_dat = v.exp_dat;
      end else begin
         ea_err = v.exp_err;
         ea_dat = v.exp_dat;
      end
      chk({p, " resp m_sel"}, 32'(bus.m_sel), 32'd0);
      chk({p, " a_listo"}, 32'(bus.a_listo), 32'(!v.srv_b));
      chk({p, " b_listo"}, 32'(bus.b_listo), 32'(v.srv_b));
      chk_puertos({p, " resp"});
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
      @(posedge clk); #1;
      chk({p, " idle a_listo"}, 32'(bus.a_listo), 32'd0);
      chk({p, " idle b_listo"}, 32'(bus.b_listo), 32'd0);
      chk({p, " idle m_sel"}, 32'(bus.m_sel), 32'd0);
      chk_puertos({p, " idle"});
   endtask

   initial begin
      //           areq  breq  aesc  besc  a_dir         b_dir
      //           a_wd          b_wd          amsk  bmsk  esp
      //           m_rd          srvb  err   dat
      tabla[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,
                   32'h0,        32'h0,        4'hF, 4'h0, 0,
                   32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF};
      tabla[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0000_0040,
                   32'h0,        32'h1234_5678, 4'h0, 4'h3, 4,
                   32'hAAAA_5555, 1'b1, 1'b0, 32'h0};
      tabla[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0300,
                   32'h0,        32'h0,        4'hF, 4'hF, 1,
                   32'h1111_2222, 1'b0, 1'b0, 32'h1111_2222};
      tabla[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0204, 32'h0000_0304,
                   32'h0,        32'h0,        4'hF, 4'hF, 0,
                   32'h3333_4444, 1'b1, 1'b0, 32'h3333_4444};
      tabla[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0208, 32'h0,
                   32'h0,        32'h0,        4'hF, 4'h0, 99,
                   32'h7777_8888, 1'b0, 1'b1, 32'h0};
      tabla[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_020C, 32'h0,
                   32'h0,        32'h0,        4'hF, 4'h0, 14,
                   32'h5A5A_5A5A, 1'b0, 1'b0, 32'h5A5A_5A5A};
      tabla[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0000_0044,
                   32'h0,        32'hCAFE_F00D, 4'h0, 4'hC, 2,
                   32'h9999_9999, 1'b1, 1'b0, 32'h0};
      tabla[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0048,
                   32'h0,        32'h0,        4'h0, 4'h1, 99,
                   32'h6666_6666, 1'b1, 1'b1, 32'h0};
      tabla[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0210, 32'h0000_0310,
                   32'hA5A5_A5A5, 32'h0,        4'h5, 4'hF, 0,
                   32'hBBBB_BBBB, 1'b0, 1'b0, 32'h0};

      reset          = 1'b0;
      bus.a_req      = 1'b0;
      bus.b_req      = 1'b0;
      bus.a_esc      = 1'b0;
      bus.b_esc      = 1'b0;
      bus.a_dir      = 32'h0;
      bus.b_dir      = 32'h0;
      bus.a_dato_esc = 32'h0;
      bus.b_dato_esc = 32'h0;
      bus.a_mascara  = 4'h0;
      bus.b_mascara  = 4'h0;
      bus.m_dato_lec = 32'h0;
      bus.m_listo    = 1'b0;

      #12;
      chk("rst m_sel", 32'(bus.m_sel), 32'd0);
      chk("rst m_esc", 32'(bus.m_esc), 32'd0);
      chk("rst m_dir", bus.m_dir, 32'd0);
      chk("rst m_dato_esc", bus.m_dato_esc, 32'd0);
      chk("rst m_mascara", 32'(bus.m_mascara), 32'd0);
      chk("rst a_listo", 32'(bus.a_listo), 32'd0);
      chk("rst b_listo", 32'(bus.b_listo), 32'd0);
      chk_puertos("rst");

      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 9; i++) run_vec(i, tabla[i]);

      // both ports requesting continuously, zero-wait memory
      bus.a_req      = 1'b1;
      bus.b_req      = 1'b1;
      bus.a_esc      = 1'b1;
      bus.b_esc      = 1'b1;
      bus.a_dir      = 32'h0000_0A00;
      bus.b_dir      = 32'h0000_0B00;
      bus.m_dato_lec = 32'hFFFF_0000;
      bus.m_listo    = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         int t;
         t = (k - 1) / 3;
         @(posedge clk); #1;
         chk($sformatf("rr%0d m_sel", k), 32'(bus.m_sel),
             32'(k % 3 == 1));
         chk($sformatf("rr%0d a_listo", k), 32'(bus.a_listo),
             32'((k % 3 == 2) && (t % 2 == 1)));
         chk($sformatf("rr%0d b_listo", k), 32'(bus.b_listo),
             32'((k % 3 == 2) && (t % 2 == 0)));
         if (k % 3 == 1)
            chk($sformatf("rr%0d m_dir", k), bus.m_dir,
                (t % 2 == 0) ? 32'h0000_0B00 : 32'h0000_0A00);
      end
      bus.a_req   = 1'b0;
      bus.b_req   = 1'b0;
      bus.m_listo = 1'b0;
      ea_err = 1'b0; ea_dat = 32'h0;
      eb_err = 1'b0; eb_dat = 32'h0;
      chk_puertos("rr end");

      // memory completion pulses while idle
      bus.m_dato_lec = 32'h1357_9BDF;
      for (int i = 0; i < 6; i++) begin
         bus.m_listo = i[0];
         @(posedge clk); #1;
         chk($sformatf("idle%0d m_sel", i), 32'(bus.m_sel), 32'd0);
         chk($sformatf("idle%0d a_listo", i), 32'(bus.a_listo), 32'd0);
         chk($sformatf("idle%0d b_listo", i), 32'(bus.b_listo), 32'd0);
      end
      bus.m_listo = 1'b0;
      chk_puertos("idle end");

      // asynchronous reset in the middle of an access
      bus.a_req = 1'b1;
      bus.b_req = 1'b1;
      bus.a_esc = 1'b0;
      bus.b_esc = 1'b0;
      bus.a_dir = 32'h0000_0400;
      bus.b_dir = 32'h0000_0500;
      @(posedge clk); #1;
      chk("ar grant m_sel", 32'(bus.m_sel), 32'd1);
      chk("ar grant m_dir", bus.m_dir, 32'h0000_0500);
      #3;
      reset = 1'b0;
      #1;
      chk("ar async m_sel", 32'(bus.m_sel), 32'd0);
      chk("ar async m_dir", bus.m_dir, 32'd0);
      chk("ar async b_listo", 32'(bus.b_listo), 32'd0);
      @(posedge clk); #1;
      bus.m_listo = 1'b1;
      @(posedge clk); #1;
      chk("ar held b_listo", 32'(bus.b_listo), 32'd0);
      chk("ar held m_sel", 32'(bus.m_sel), 32'd0);
      @(negedge clk);
      bus.m_listo = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("ar regrant m_sel", 32'(bus.m_sel), 32'd1);
      chk("ar regrant m_dir", bus.m_dir, 32'h0000_0400);
      chk("ar regrant b_listo", 32'(bus.b_listo), 32'd0);
      bus.m_dato_lec = 32'h0BAD_F00D;
      bus.m_listo    = 1'b1;
      @(posedge clk); #1;
      bus.m_listo = 1'b0;
      chk("ar resp a_listo", 32'(bus.a_listo), 32'd1);
      chk("ar resp b_listo", 32'(bus.b_listo), 32'd0);
      chk("ar resp a_dato_lec", bus.a_dato_lec, 32'h0BAD_F00D);
      chk("ar resp a_error", 32'(bus.a_error), 32'd0);
      #2;
      reset = 1'b0;
      #1;
      chk("ar resp-rst a_listo", 32'(bus.a_listo), 32'd0);
      chk("ar resp-rst a_dato_lec", bus.a_dato_lec, 32'd0);
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk($sformatf("ar after%0d m_sel", i), 32'(bus.m_sel), 32'd0);
         chk($sformatf("ar after%0d a_listo", i),
             32'(bus.a_listo), 32'd0);
         chk($sformatf("ar after%0d b_listo", i),
             32'(bus.b_listo), 32'd0);
      end

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
